// File: rtl/output_stream_writer_pkg.sv
// Shared types and width helpers for the output stream writer burst scheduler.
package output_stream_writer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_LEN,
    ST_ISSUE
  } state_t;

  // Descriptor fields are sized for the default 48-bit address / 4 KiB burst configuration.
  localparam int DESC_ADDR_BITS = 48;
  localparam int DESC_LEN_BITS  = 13;

  typedef struct packed {
    logic [DESC_ADDR_BITS-1:0] addr;
    logic [DESC_LEN_BITS-1:0]  len;
    logic                      last;
  } desc_t;

  function automatic int chunk_bits(input int max_burst_bytes);
    return $clog2(max_burst_bytes) + 1;
  endfunction

  function automatic int credit_bits(input int max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

endpackage

// File: rtl/output_stream_writer_burst_scheduler_credit_counter.sv
// Tracks issued-but-uncompleted descriptors; completions at zero are flagged, not counted.
module credit_counter
  import output_stream_writer_pkg::*;
#(
  parameter int MAX = 8,
  parameter int W   = credit_bits(MAX)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         full,
  output logic         underflow
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else begin
      case ({inc, dec})
        2'b10:   count <= count + W'(1);
        2'b01:   if (count != '0) count <= count - W'(1);
        default: count <= count;
      endcase
    end
  end

  assign full      = (count == W'(MAX));
  assign underflow = dec && (count == '0);

endmodule

// File: rtl/output_stream_writer_burst_scheduler.sv
// Splits transfer lengths into boundary-aligned write bursts, throttled by a completion credit counter.
module output_stream_writer_burst_scheduler
  import output_stream_writer_pkg::*;
#(
  parameter int TRANSFER_ADDRESS_LEN_BITS = 32,
  parameter int VADDR_BITS                = 48,
  parameter int MAX_BURST_BYTES           = 4096,
  parameter int MAX_OUTSTANDING           = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [VADDR_BITS-1:0]                  i_cfg_addr,
  input  logic                                   i_cfg_valid,
  output logic                                   o_cfg_ready,
  input  logic [TRANSFER_ADDRESS_LEN_BITS-1:0]   i_len_data,
  input  logic                                   i_len_valid,
  output logic                                   o_len_ready,
  output logic [VADDR_BITS-1:0]                  o_desc_addr,
  output logic [chunk_bits(MAX_BURST_BYTES)-1:0] o_desc_len,
  output logic                                   o_desc_last,
  output logic                                   o_desc_valid,
  input  logic                                   i_desc_ready,
  input  logic                                   i_done,
  output logic [credit_bits(MAX_OUTSTANDING)-1:0] o_outstanding,
  output logic                                   o_busy,
  output logic                                   o_err
);

  localparam int CHUNK_BITS  = chunk_bits(MAX_BURST_BYTES);
  localparam int CREDIT_BITS = credit_bits(MAX_OUTSTANDING);
  localparam int OFF_BITS    = $clog2(MAX_BURST_BYTES);
  localparam int LEN_BITS    = TRANSFER_ADDRESS_LEN_BITS;

  state_t                 state, state_next;
  logic [VADDR_BITS-1:0]  cur_addr;
  logic [LEN_BITS-1:0]    remaining;
  logic [CHUNK_BITS-1:0]  room, chunk;
  logic                   last;
  logic                   cfg_hs, len_hs, desc_hs;
  logic                   credit_full, underflow;
  logic [CREDIT_BITS-1:0] outstanding;
  desc_t                  desc;

  assign cfg_hs  = i_cfg_valid && o_cfg_ready;
  assign len_hs  = i_len_valid && o_len_ready;
  assign desc_hs = o_desc_valid && i_desc_ready;

  credit_counter #(.MAX(MAX_OUTSTANDING), .W(CREDIT_BITS)) u_credits (
    .clk       (clk),
    .rst       (rst),
    .inc       (desc_hs),
    .dec       (i_done),
    .count     (outstanding),
    .full      (credit_full),
    .underflow (underflow)
  );

  // A burst stops at the next MAX_BURST_BYTES boundary or at the end of the transfer.
  always_comb begin
    room  = CHUNK_BITS'(MAX_BURST_BYTES) - {1'b0, cur_addr[OFF_BITS-1:0]};
    chunk = (remaining < LEN_BITS'(room)) ? remaining[CHUNK_BITS-1:0] : room;
    last  = (LEN_BITS'(chunk) == remaining);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (cfg_hs) state_next = ST_WAIT_LEN;
      ST_WAIT_LEN: if (len_hs && (i_len_data != '0)) state_next = ST_ISSUE;
      ST_ISSUE:    if (desc_hs && last) state_next = ST_WAIT_LEN;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_cfg_ready  = 1'b0;
    o_len_ready  = 1'b0;
    o_desc_valid = 1'b0;
    o_desc_addr  = '0;
    o_desc_len   = '0;
    o_desc_last  = 1'b0;
    desc.addr    = DESC_ADDR_BITS'(cur_addr);
    desc.len     = DESC_LEN_BITS'(chunk);
    desc.last    = last;
    case (state)
      ST_IDLE: o_cfg_ready = 1'b1;
      ST_WAIT_LEN: begin
        o_cfg_ready = 1'b1;
        o_len_ready = !i_cfg_valid;
      end
      ST_ISSUE: begin
        o_desc_valid = !credit_full;
        o_desc_addr  = VADDR_BITS'(desc.addr);
        o_desc_len   = CHUNK_BITS'(desc.len);
        o_desc_last  = desc.last;
      end
      default: ;
    endcase
  end

  // cur_addr carries over between transfers so consecutive lengths pack back-to-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr  <= '0;
      remaining <= '0;
      o_err     <= 1'b0;
    end else begin
      if (cfg_hs)       cur_addr <= i_cfg_addr;
      else if (desc_hs) cur_addr <= cur_addr + VADDR_BITS'(chunk);
      if (len_hs)       remaining <= i_len_data;
      else if (desc_hs) remaining <= remaining - LEN_BITS'(chunk);
      if (underflow)    o_err <= 1'b1;
    end
  end

  assign o_outstanding = outstanding;
  assign o_busy        = (state == ST_ISSUE) || (outstanding != '0);

endmodule

// File: tb/tb_output_stream_writer_burst_scheduler.sv
// Scoreboard bench: a reference splitter queues expected bursts; a monitor checks each handshake.
module tb_output_stream_writer_burst_scheduler;

  localparam int MB = 4096;

  typedef struct {
    logic [47:0] addr;
    logic [12:0] len;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] i_cfg_addr = '0;
  logic        i_cfg_valid = 1'b0;
  logic [31:0] i_len_data = '0;
  logic        i_len_valid = 1'b0;
  logic        i_desc_ready;
  logic        i_done;

  logic        ready_cmd = 1'b1, rand_ready = 1'b0, rnd_bit = 1'b1;
  logic        auto_en = 1'b1, auto_pulse = 1'b0, man_done = 1'b0;
  logic        use_small = 1'b0;

  logic        cfg_ready8, len_ready8, last8, valid8, busy8, err8;
  logic [47:0] addr8;
  logic [12:0] len8;
  logic [3:0]  out8;
  logic        cfg_ready2, len_ready2, last2, valid2, busy2, err2;
  logic [47:0] addr2;
  logic [12:0] len2;
  logic [1:0]  out2;

  logic        mon_cfg_ready, mon_len_ready, mon_last, mon_valid, mon_busy, mon_err;
  logic [47:0] mon_addr;
  logic [12:0] mon_len;
  logic [3:0]  mon_out;

  exp_t        q[$];
  logic [47:0] model_addr = '0;
  int          checks = 0;
  int          errors = 0;

  assign i_desc_ready = rand_ready ? rnd_bit : ready_cmd;
  assign i_done       = auto_en ? auto_pulse : man_done;

  assign mon_cfg_ready = use_small ? cfg_ready2 : cfg_ready8;
  assign mon_len_ready = use_small ? len_ready2 : len_ready8;
  assign mon_valid     = use_small ? valid2 : valid8;
  assign mon_addr      = use_small ? addr2 : addr8;
  assign mon_len       = use_small ? len2 : len8;
  assign mon_last      = use_small ? last2 : last8;
  assign mon_out       = use_small ? {2'b00, out2} : out8;
  assign mon_busy      = use_small ? busy2 : busy8;
  assign mon_err       = use_small ? err2 : err8;

  output_stream_writer_burst_scheduler dut (
    .clk(clk), .rst(rst),
    .i_cfg_addr(i_cfg_addr), .i_cfg_valid(i_cfg_valid), .o_cfg_ready(cfg_ready8),
    .i_len_data(i_len_data), .i_len_valid(i_len_valid), .o_len_ready(len_ready8),
    .o_desc_addr(addr8), .o_desc_len(len8), .o_desc_last(last8),
    .o_desc_valid(valid8), .i_desc_ready(i_desc_ready), .i_done(i_done),
    .o_outstanding(out8), .o_busy(busy8), .o_err(err8)
  );

  output_stream_writer_burst_scheduler #(.MAX_OUTSTANDING(2)) dut_small (
    .clk(clk), .rst(rst),
    .i_cfg_addr(i_cfg_addr), .i_cfg_valid(i_cfg_valid), .o_cfg_ready(cfg_ready2),
    .i_len_data(i_len_data), .i_len_valid(i_len_valid), .o_len_ready(len_ready2),
    .o_desc_addr(addr2), .o_desc_len(len2), .o_desc_last(last2),
    .o_desc_valid(valid2), .i_desc_ready(i_desc_ready), .i_done(i_done),
    .o_outstanding(out2), .o_busy(busy2), .o_err(err2)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Completion responder and random backpressure, updated just after each edge.
  always @(posedge clk) begin
    #1;
    auto_pulse = auto_en && (mon_out != 4'd0);
    rnd_bit    = 1'($urandom_range(0, 1));
  end

  // A handshake happens at the next posedge whenever valid and ready are both high mid-cycle.
  always @(negedge clk) begin
    if (mon_valid && i_desc_ready) begin
      if (q.size() == 0) begin
        checkOutput("desc_unexpected", 64'(mon_addr), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        checkOutput("desc_addr", 64'(mon_addr), 64'(e.addr));
        checkOutput("desc_len",  64'(mon_len),  64'(e.len));
        checkOutput("desc_last", 64'(mon_last), 64'(e.last));
      end
    end
  end

  task automatic applyReset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    model_addr = '0;
  endtask

  task automatic applyConfig(input logic [47:0] addr);
    bit ok = 0;
    i_cfg_addr  = addr;
    i_cfg_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mon_cfg_ready) begin ok = 1; break; end
    end
    if (!ok) checkOutput("cfg_timeout", 0, 1);
    else model_addr = addr;
    @(posedge clk); #1;
    i_cfg_valid = 1'b0;
  endtask

  task automatic applyStimulus(input logic [31:0] len);
    bit ok = 0;
    i_len_data  = len;
    i_len_valid = 1'b1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (mon_len_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      checkOutput("len_timeout", 0, 1);
    end else begin
      int unsigned rem = len;
      while (rem != 0) begin
        exp_t e;
        int unsigned room_v, ch;
        room_v = MB - {20'd0, model_addr[11:0]};
        ch     = (rem < room_v) ? rem : room_v;
        e.addr = model_addr;
        e.len  = 13'(ch);
        e.last = (ch == rem);
        q.push_back(e);
        model_addr = model_addr + 48'(ch);
        rem = rem - ch;
      end
    end
    @(posedge clk); #1;
    i_len_valid = 1'b0;
  endtask

  task automatic waitDrained(input string tag);
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (q.size() == 0) begin ok = 1; break; end
      @(negedge clk);
    end
    if (!ok) checkOutput({tag, "_drain_timeout"}, 64'(q.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic waitIdle(input string tag);
    bit ok = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!mon_busy) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    if (!ok) checkOutput({tag, "_idle_timeout"}, 1, 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("rst_cfg_ready",   64'(mon_cfg_ready), 1);
    checkOutput("rst_len_ready",   64'(mon_len_ready), 0);
    checkOutput("rst_desc_valid",  64'(mon_valid), 0);
    checkOutput("rst_desc_addr",   64'(mon_addr), 0);
    checkOutput("rst_desc_len",    64'(mon_len), 0);
    checkOutput("rst_desc_last",   64'(mon_last), 0);
    checkOutput("rst_outstanding", 64'(mon_out), 0);
    checkOutput("rst_busy",        64'(mon_busy), 0);
    checkOutput("rst_err",         64'(mon_err), 0);

    $display("[TB] 10000 bytes from 0x1000");
    applyConfig(48'h1000);
    applyStimulus(32'd10000);
    waitDrained("t1");
    checkOutput("t1_len_ready_after_last", 64'(mon_len_ready), 1);
    waitIdle("t1");

    $display("[TB] 512 bytes across a 4 KiB boundary, random backpressure");
    rand_ready = 1'b1;
    applyConfig(48'h0F00);
    applyStimulus(32'd512);
    waitDrained("t2");
    rand_ready = 1'b0;
    waitIdle("t2");

    $display("[TB] zero length then back-to-back transfers");
    applyConfig(48'h0);
    applyStimulus(32'd0);
    checkOutput("t3_len0_len_ready", 64'(mon_len_ready), 1);
    checkOutput("t3_len0_no_desc",   64'(mon_valid), 0);
    @(posedge clk); #1;
    checkOutput("t3_len0_no_desc_later", 64'(mon_valid), 0);
    applyStimulus(32'd64);
    applyStimulus(32'd32);
    waitDrained("t3");
    waitIdle("t3");

    $display("[TB] credit limit of two");
    use_small = 1'b1;
    applyReset();
    auto_en = 1'b0;
    applyConfig(48'h0);
    applyStimulus(32'd16384);
    begin
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
        if (mon_out == 4'd2 && !mon_valid) begin ok = 1; break; end
        @(posedge clk); #1;
      end
      if (!ok) checkOutput("t4_stall_timeout", 0, 1);
    end
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t4_stall_valid", 64'(mon_valid), 0);
    checkOutput("t4_stall_count", 64'(mon_out), 2);
    checkOutput("t4_stall_busy",  64'(mon_busy), 1);
    checkOutput("t4_stall_queue", 64'(q.size()), 2);
    man_done = 1'b1;
    @(posedge clk); #1;
    checkOutput("t4_credit_valid", 64'(mon_valid), 1);
    checkOutput("t4_credit_count", 64'(mon_out), 1);
    @(posedge clk); #1;
    man_done = 1'b0;
    checkOutput("t4_concurrent_count", 64'(mon_out), 1);
    auto_en = 1'b1;
    waitDrained("t4");
    waitIdle("t4");
    checkOutput("t4_err", 64'(mon_err), 0);

    $display("[TB] completion underflow and config priority");
    use_small = 1'b0;
    applyReset();
    auto_en  = 1'b0;
    man_done = 1'b1;
    @(posedge clk); #1;
    man_done = 1'b0;
    checkOutput("t5_err_set",     64'(mon_err), 1);
    checkOutput("t5_count_zero",  64'(mon_out), 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t5_err_sticky",  64'(mon_err), 1);
    applyConfig(48'h0);
    i_cfg_addr  = 48'h5000;
    i_cfg_valid = 1'b1;
    i_len_data  = 32'd128;
    i_len_valid = 1'b1;
    #1;
    checkOutput("t5_prio_len_ready", 64'(mon_len_ready), 0);
    checkOutput("t5_prio_cfg_ready", 64'(mon_cfg_ready), 1);
    @(posedge clk); #1;
    i_cfg_valid = 1'b0;
    i_len_valid = 1'b0;
    model_addr  = 48'h5000;
    auto_en     = 1'b1;
    applyStimulus(32'd64);
    waitDrained("t5");
    waitIdle("t5");
    checkOutput("t5_err_still", 64'(mon_err), 1);

    $display("[TB] reset in the middle of a transfer");
    applyReset();
    checkOutput("t6_err_cleared", 64'(mon_err), 0);
    auto_en = 1'b0;
    applyConfig(48'h0);
    applyStimulus(32'd16384);
    begin
      bit ok = 0;
      for (int i = 0; i < 50; i++) begin
        if (q.size() == 2) begin ok = 1; break; end
        @(posedge clk); #1;
      end
      if (!ok) checkOutput("t6_progress_timeout", 0, 1);
    end
    checkOutput("t6_mid_count", 64'(mon_out), 2);
    checkOutput("t6_mid_valid", 64'(mon_valid), 1);
    ready_cmd = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    model_addr = '0;
    checkOutput("t6_rst_valid",     64'(mon_valid), 0);
    checkOutput("t6_rst_cfg_ready", 64'(mon_cfg_ready), 1);
    checkOutput("t6_rst_len_ready", 64'(mon_len_ready), 0);
    checkOutput("t6_rst_count",     64'(mon_out), 0);
    checkOutput("t6_rst_busy",      64'(mon_busy), 0);
    ready_cmd = 1'b1;
    man_done  = 1'b1;
    @(posedge clk); #1;
    man_done = 1'b0;
    checkOutput("t6_late_done_err",   64'(mon_err), 1);
    checkOutput("t6_late_done_count", 64'(mon_out), 0);
    applyReset();
    auto_en = 1'b1;
    applyConfig(48'h7000);
    applyStimulus(32'd8192);
    waitDrained("t6");
    waitIdle("t6");
    checkOutput("t6_final_err", 64'(mon_err), 0);
    checkOutput("t6_queue_empty", 64'(q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/output_stream_writer_burst_scheduler.md
# output_stream_writer_burst_scheduler

Sequences the output stream writer's write bursts by consuming transfer lengths from the writer's length FIFO. Each length is split into write descriptors of at most MAX_BURST_BYTES, and no descriptor crosses a MAX_BURST_BYTES-aligned address boundary. A credit counter limits the number of issued-but-uncompleted descriptors. Sits between the length FIFO output and the memory write-request interface.

## Interface
- TRANSFER_ADDRESS_LEN_BITS, 32, width of a transfer length in bytes
- VADDR_BITS, 48, write address width
- MAX_BURST_BYTES, 4096, maximum descriptor length and alignment boundary; power of two
- MAX_OUTSTANDING, 8, maximum uncompleted descriptors; ≥1

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_cfg_addr  in  VADDR_BITS  start address of the next output region
- i_cfg_valid  in  1  config valid
- o_cfg_ready  out  1  config ready
- i_len_data  in  TRANSFER_ADDRESS_LEN_BITS  transfer length in bytes
- i_len_valid  in  1  length valid
- o_len_ready  out  1  length ready
- o_desc_addr  out  VADDR_BITS  burst start address
- o_desc_len  out  CHUNK_BITS  burst length in bytes; CHUNK_BITS = $clog2(MAX_BURST_BYTES)+1
- o_desc_last  out  1  final burst of the current transfer
- o_desc_valid  out  1  descriptor valid
- i_desc_ready  in  1  descriptor ready
- i_done  in  1  one-cycle pulse per completed descriptor
- o_outstanding  out  $clog2(MAX_OUTSTANDING+1)  uncompleted descriptors
- o_busy  out  1  state is ST_ISSUE or o_outstanding≠0
- o_err  out  1  sticky; set by i_done while o_outstanding==0

## Operation
- States:
  - ST_IDLE: entered from reset. o_cfg_ready=1. A cfg handshake loads cur_addr and moves to ST_WAIT_LEN.
  - ST_WAIT_LEN:
    - o_cfg_ready=1.
    - o_len_ready = !i_cfg_valid; config has priority when both are valid in the same cycle.
    - A cfg handshake reloads cur_addr and stays in ST_WAIT_LEN.
    - A len handshake with length 0 is consumed silently: no descriptor, stay in ST_WAIT_LEN.
    - A len handshake with length ≠0 loads remaining and moves to ST_ISSUE.
  - ST_ISSUE:
    - chunk = min(remaining, MAX_BURST_BYTES − (cur_addr mod MAX_BURST_BYTES)).
    - o_desc_valid = (o_outstanding < MAX_OUTSTANDING).
    - o_desc_addr = cur_addr, o_desc_len = chunk, o_desc_last = (chunk == remaining).
    - On handshake: cur_addr += chunk, remaining −= chunk. If last, go to ST_WAIT_LEN.
- cur_addr persists across transfers. Consecutive lengths are written back-to-back until a new cfg arrives.
- cur_addr wraps modulo 2^VADDR_BITS.
- The chunk is always ≤ MAX_BURST_BYTES and fits in CHUNK_BITS.
- Credit counter:
  - +1 on a descriptor handshake; −1 on i_done.
  - Both in the same cycle: count unchanged.
  - i_done at count 0: count stays 0 and o_err is set.

## Timing
- Reset values:
  - state ST_IDLE, so o_cfg_ready=1.
  - o_len_ready=0, o_desc_valid=0, o_desc_addr=0, o_desc_len=0, o_desc_last=0.
  - o_outstanding=0, o_busy=0, o_err=0.
- Length handshake in cycle N → o_desc_valid=1 in N+1 if a credit is free. A credit freed by i_done in cycle M allows o_desc_valid in M+1.
- Back-to-back descriptors: one per cycle while i_desc_ready=1 and credits remain.
- Once o_desc_valid is asserted, it and all descriptor fields stay stable until the handshake. Credits only grow without a handshake, so valid cannot drop.
- After the last descriptor's handshake in cycle N, o_len_ready=1 in N+1. Minimum one idle cycle between transfers.
- Reset mid-operation:
  - All state, including remaining, cur_addr and credits, is discarded.
  - Outputs take their reset values in the cycle after rst is sampled high.
  - Late i_done pulses after reset set o_err.

## Structure
- Package output_stream_writer_pkg holds:
  - the state enum (ST_IDLE, ST_WAIT_LEN, ST_ISSUE)
  - the desc_t struct (addr, len, last)
  - the CHUNK_BITS and credit-width functions
- Sub-module: credit_counter, parameterised by MAX, with inc/dec/count/full/underflow signals. The scheduler FSM, chunk computation and address registers stay in the top.

## Test plan
Default parameters unless stated.
- cfg 0x1000, len 10000 → descriptors (0x1000,4096,0), (0x2000,4096,0), (0x3000,1808,1). Then o_len_ready=1.
- cfg 0x0F00, len 512 → (0x0F00,256,0), (0x1000,256,1). No descriptor crosses 0x1000.
- cfg 0x0, len 0 → no descriptor and o_len_ready stays 1. Then len 64 → (0x0,64,1). Then len 32 → (0x40,32,1).
- MAX_OUTSTANDING=2, cfg 0x0, len 16384, i_done held low, i_desc_ready=1 → two descriptors, then o_desc_valid=0 with o_outstanding=2. One i_done pulse → (0x2000,4096,0) issued the next cycle. i_done concurrent with a handshake leaves the count unchanged.
- i_done with o_outstanding=0 → o_err=1 and remains set; o_outstanding stays 0. Same cycle i_cfg_valid and i_len_valid in ST_WAIT_LEN → cfg taken, o_len_ready=0.
- rst asserted in ST_ISSUE mid-transfer → next cycle o_desc_valid=0, o_cfg_ready=1, o_outstanding=0, o_busy=0. A new cfg/len pair then schedules correctly from scratch.
